// File: rtl/sram_arbiter.sv
// Round-robin arbiter and strobe sequencer between two requesters and a 64K x 8 asynchronous SRAM.
// Every pin-facing output is registered; the data bus is driven from a registered output-enable.
module sram_arbiter #(
   parameter int AW      = 16,
   parameter int DW      = 8,
   parameter int RD_WAIT = 2,
   parameter int WR_WAIT = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_req,
   input  logic          a_rnw,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_ack,
   output logic          a_done,
   input  logic          b_req,
   input  logic          b_rnw,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_ack,
   output logic          b_done,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] sram_addr,
   inout  wire  [DW-1:0] sram_d,
   output logic          sram_ce_n,
   output logic          sram_oe_n,
   output logic          sram_we_n
);

   localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
   localparam int CW       = $clog2(MAX_WAIT + 1);

   typedef enum logic [2:0] {IDLE, SETUP, RD, WR, END} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          grant_a, grant_b;
   logic          sel_b_q, sel_b_d;   // winner of the current access, doubles as last-served pointer
   logic          rnw_q, rnw_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          drive_q, drive_d;
   logic [DW-1:0] rdata_q;
   logic          ce_n_q, oe_n_q, we_n_q;
   logic          a_ack_q, b_ack_q, a_done_q, b_done_q;
   logic          last_wait;

   assign last_wait = (cnt_q <= CW'(1));

   // NOTE: every variable gets a default before the case, so no path leaves one unassigned (no latch).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant_a = 1'b0;
      grant_b = 1'b0;
      sel_b_d = sel_b_q;
      rnw_d   = rnw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (a_req && (!b_req || sel_b_q)) grant_a = 1'b1;
            else if (b_req)                   grant_b = 1'b1;
            if (grant_a || grant_b) begin
               sel_b_d = grant_b;
               rnw_d   = grant_b ? b_rnw   : a_rnw;
               addr_d  = grant_b ? b_addr  : a_addr;
               wdata_d = grant_b ? b_wdata : a_wdata;
               state_d = SETUP;
            end
         end
         SETUP: begin
            state_d = rnw_q ? RD : WR;
            cnt_d   = rnw_q ? CW'(RD_WAIT) : CW'(WR_WAIT);
         end
         RD, WR: begin
            if (last_wait) state_d = END;
            else           cnt_d   = cnt_q - CW'(1);
         end
         END:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Write data stays on the bus from SETUP through END to give the SRAM setup and hold margin.
   assign drive_d = !rnw_d && ((state_d == SETUP) || (state_d == WR) || (state_d == END));

   // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sel_b_q  <= 1'b1;
         rnw_q    <= 1'b1;
         addr_q   <= '0;
         wdata_q  <= '0;
         drive_q  <= 1'b0;
         rdata_q  <= '0;
         ce_n_q   <= 1'b1;
         oe_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
         a_ack_q  <= 1'b0;
         b_ack_q  <= 1'b0;
         a_done_q <= 1'b0;
         b_done_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_b_q  <= sel_b_d;
         rnw_q    <= rnw_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         drive_q  <= drive_d;
         ce_n_q   <= (state_d == IDLE);
         oe_n_q   <= (state_d != RD);
         we_n_q   <= (state_d != WR);
         a_ack_q  <= grant_a;
         b_ack_q  <= grant_b;
         a_done_q <= (state_d == END) && !sel_b_q;
         b_done_q <= (state_d == END) &&  sel_b_q;
         if ((state_q == RD) && last_wait) rdata_q <= sram_d;
      end
   end

   assign sram_d    = drive_q ? wdata_q : 'z;
   assign sram_addr = addr_q;
   assign sram_ce_n = ce_n_q;
   assign sram_oe_n = oe_n_q;
   assign sram_we_n = we_n_q;
   assign rdata     = rdata_q;
   assign a_ack     = a_ack_q;
   assign b_ack     = b_ack_q;
   assign a_done    = a_done_q;
   assign b_done    = b_done_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed single accesses, tie arbitration, reset abort mid-write,
// and a read wait-state sweep on two extra instances. The data bus is pulled high so a released bus reads FF.
`timescale 1ns/1ps
module tb_sram_arbiter;

   localparam int RDW = 2;
   localparam int WRW = 2;
   localparam logic [7:0] SW_DATA = 8'h96;   // 8'h33 ^ 8'hA5, what the sweep SRAM returns

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_req = 1'b0, a_rnw = 1'b0, b_req = 1'b0, b_rnw = 1'b0;
   logic [15:0] a_addr = '0, b_addr = '0;
   logic [7:0]  a_wdata = '0, b_wdata = '0;
   logic        a_ack, a_done, b_ack, b_done;
   logic [7:0]  rdata;
   logic [15:0] sram_addr;
   tri1  [7:0]  sram_d;
   logic        sram_ce_n, sram_oe_n, sram_we_n;
   logic [7:0]  mem [0:65535];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct packed {
      logic        pb;
      logic        rnw;
      logic [15:0] addr;
      logic [7:0]  data;
      logic [7:0]  lat;
   } exp_t;

   exp_t done_q[$];
   logic ack_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sram_arbiter #(.AW(16), .DW(8), .RD_WAIT(RDW), .WR_WAIT(WRW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_rnw(a_rnw), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_done(a_done),
      .b_req(b_req), .b_rnw(b_rnw), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_done(b_done),
      .rdata(rdata), .sram_addr(sram_addr), .sram_d(sram_d),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
   );

   // Asynchronous SRAM model: drives on read, latches the bus while we_n is low.
   assign sram_d = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 8'bz;
   always @(negedge clk)
      if (!rst_n) mem[16'h1234] <= 8'h5A;
      else if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_d;

   // Two sweep instances: RD_WAIT 1 and 5, WR_WAIT 3.
   logic        sw_req [2] = '{1'b0, 1'b0};
   logic        sw_ack [2], sw_done [2], sw_back [2], sw_bdone [2];
   logic        sw_ce_n [2], sw_oe_n [2], sw_we_n [2];
   logic [7:0]  sw_rdata [2];
   logic [15:0] sw_addr [2];
   tri1  [7:0]  sw_d0, sw_d1;
   int          sw_ow [2] = '{0, 0};
   int          sw_nd [2] = '{0, 0};
   int          sw_prev [2] = '{0, 0};

   sram_arbiter #(.AW(16), .DW(8), .RD_WAIT(1), .WR_WAIT(3)) u_sw1 (
      .clk(clk), .rst_n(rst_n),
      .a_req(sw_req[0]), .a_rnw(1'b1), .a_addr(16'h0033), .a_wdata(8'h00), .a_ack(sw_ack[0]), .a_done(sw_done[0]),
      .b_req(1'b0), .b_rnw(1'b0), .b_addr(16'h0000), .b_wdata(8'h00), .b_ack(sw_back[0]), .b_done(sw_bdone[0]),
      .rdata(sw_rdata[0]), .sram_addr(sw_addr[0]), .sram_d(sw_d0),
      .sram_ce_n(sw_ce_n[0]), .sram_oe_n(sw_oe_n[0]), .sram_we_n(sw_we_n[0])
   );

   sram_arbiter #(.AW(16), .DW(8), .RD_WAIT(5), .WR_WAIT(3)) u_sw5 (
      .clk(clk), .rst_n(rst_n),
      .a_req(sw_req[1]), .a_rnw(1'b1), .a_addr(16'h0033), .a_wdata(8'h00), .a_ack(sw_ack[1]), .a_done(sw_done[1]),
      .b_req(1'b0), .b_rnw(1'b0), .b_addr(16'h0000), .b_wdata(8'h00), .b_ack(sw_back[1]), .b_done(sw_bdone[1]),
      .rdata(sw_rdata[1]), .sram_addr(sw_addr[1]), .sram_d(sw_d1),
      .sram_ce_n(sw_ce_n[1]), .sram_oe_n(sw_oe_n[1]), .sram_we_n(sw_we_n[1])
   );

   assign sw_d0 = (!sw_ce_n[0] && !sw_oe_n[0]) ? (sw_addr[0][7:0] ^ 8'hA5) : 8'bz;
   assign sw_d1 = (!sw_ce_n[1] && !sw_oe_n[1]) ? (sw_addr[1][7:0] ^ 8'hA5) : 8'bz;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(input logic pb, input logic rnw, input logic [15:0] addr, input logic [7:0] data);
      exp_t e;
      e.pb   = pb;
      e.rnw  = rnw;
      e.addr = addr;
      e.data = data;
      e.lat  = rnw ? 8'(RDW + 1) : 8'(WRW + 1);
      return e;
   endfunction

   // Monitor: invariants every cycle, pops the scoreboard on each ack and done.
   int   ack_cyc = 0, oe_w = 0, we_w = 0;
   logic [7:0] last_rd = 8'h00;
   exp_t e_mon;

   always @(negedge clk) begin
      if (!rst_n) begin
         oe_w = 0;
         we_w = 0;
         last_rd = 8'h00;
      end else begin
         check("oe_we_exclusive", 32'(!sram_oe_n && !sram_we_n), 32'd0);
         if (sram_ce_n) check("bus_released_idle", 32'(sram_d), 32'hFF);
         if (!sram_oe_n) oe_w++;
         else if (oe_w != 0) begin check("oe_width", 32'(oe_w), 32'(RDW)); oe_w = 0; end
         if (!sram_we_n) begin
            we_w++;
            if (done_q.size() != 0) check("wr_data_on_bus", 32'(sram_d), 32'(done_q[0].data));
         end else if (we_w != 0) begin check("we_width", 32'(we_w), 32'(WRW)); we_w = 0; end
         if (a_ack || b_ack) begin
            check("single_ack", 32'(a_ack && b_ack), 32'd0);
            if (ack_q.size() == 0) check("ack_expected", 32'(ack_q.size()), 32'd1);
            else check("ack_port", 32'(b_ack), 32'(ack_q.pop_front()));
            ack_cyc = cyc;
            if (done_q.size() != 0 && !done_q[0].rnw)
               check("setup_wr_data", 32'(sram_d), 32'(done_q[0].data));
         end
         if (a_done || b_done) begin
            check("single_done", 32'(a_done && b_done), 32'd0);
            if (done_q.size() == 0) check("done_expected", 32'(done_q.size()), 32'd1);
            else begin
               e_mon = done_q.pop_front();
               check("done_port", 32'(b_done), 32'(e_mon.pb));
               check("done_latency", 32'(cyc - ack_cyc), 32'(e_mon.lat));
               check("done_addr", 32'(sram_addr), 32'(e_mon.addr));
               if (e_mon.rnw) begin
                  check("rdata", 32'(rdata), 32'(e_mon.data));
                  last_rd = e_mon.data;
               end else begin
                  check("wr_hold_data", 32'(sram_d), 32'(e_mon.data));
                  check("rdata_kept", 32'(rdata), 32'(last_rd));
               end
            end
         end
      end
   end

   // Sweep monitor: oe_n width, read period and returned data on each instance.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            automatic int rw = (k == 0) ? 1 : 5;
            check("sw_oe_we_exclusive", 32'(!sw_oe_n[k] && !sw_we_n[k]), 32'd0);
            if (sw_back[k] || sw_bdone[k]) check("sw_port_b_idle", 32'(sw_back[k] || sw_bdone[k]), 32'd0);
            if (!sw_oe_n[k]) begin
               sw_ow[k]++;
               check("sw_bus_conflict", 32'((k == 0) ? sw_d0 : sw_d1), 32'(SW_DATA));
            end else if (sw_ow[k] != 0) begin
               check("sw_oe_width", 32'(sw_ow[k]), 32'(rw));
               sw_ow[k] = 0;
            end
            if (sw_done[k]) begin
               check("sw_rdata", 32'(sw_rdata[k]), 32'(SW_DATA));
               if (sw_nd[k] != 0) check("sw_read_period", 32'(cyc - sw_prev[k]), 32'(rw + 3));
               sw_prev[k] = cyc;
               sw_nd[k]++;
            end
         end
      end
   end

   task automatic wait_ack(input logic pb, input string name);
      int n = 0;
      do begin @(negedge clk); n++; end while (!(pb ? b_ack : a_ack) && n < 40);
      check({name, "_ack_seen"}, 32'(pb ? b_ack : a_ack), 32'd1);
      if (pb) b_req = 1'b0;
      else    a_req = 1'b0;
   endtask

   task automatic issue(input logic pb, input logic rnw, input logic [15:0] addr, input logic [7:0] data);
      ack_q.push_back(pb);
      done_q.push_back(mk(pb, rnw, addr, data));
      if (pb) begin
         b_rnw = rnw; b_addr = addr; b_wdata = rnw ? 8'h00 : data; b_req = 1'b1;
      end else begin
         a_rnw = rnw; a_addr = addr; a_wdata = rnw ? 8'h00 : data; a_req = 1'b1;
      end
      wait_ack(pb, "issue");
   endtask

   task automatic wait_idle();
      int n = 0;
      while (done_q.size() != 0 && n < 60) begin @(negedge clk); n++; end
      check("pending_done", 32'(done_q.size()), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int n, na, nb;
      int sw_na [2];
      repeat (3) @(negedge clk);
      check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
      check("rst_bus", 32'(sram_d), 32'hFF);
      check("rst_addr", 32'(sram_addr), 32'h0);
      check("rst_rdata", 32'(rdata), 32'h0);
      check("rst_handshake", 32'({a_ack, b_ack, a_done, b_done}), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(1'b0, 1'b1, 16'h1234, 8'h5A); wait_idle();
      issue(1'b1, 1'b0, 16'hFFFF, 8'hC3); wait_idle();
      issue(1'b0, 1'b0, 16'h0001, 8'h3C); wait_idle();
      issue(1'b0, 1'b1, 16'h0001, 8'h3C); wait_idle();
      issue(1'b1, 1'b1, 16'hFFFF, 8'hC3); wait_idle();

      // Tie: both held for four accesses; B was served last, so A goes first.
      ack_q.push_back(1'b0); ack_q.push_back(1'b1); ack_q.push_back(1'b0); ack_q.push_back(1'b1);
      done_q.push_back(mk(1'b0, 1'b1, 16'h1234, 8'h5A));
      done_q.push_back(mk(1'b1, 1'b1, 16'hFFFF, 8'hC3));
      done_q.push_back(mk(1'b0, 1'b1, 16'h1234, 8'h5A));
      done_q.push_back(mk(1'b1, 1'b1, 16'hFFFF, 8'hC3));
      a_rnw = 1'b1; a_addr = 16'h1234; b_rnw = 1'b1; b_addr = 16'hFFFF;
      a_req = 1'b1; b_req = 1'b1;
      n = 0; na = 0; nb = 0;
      while ((a_req || b_req) && n < 80) begin
         @(negedge clk); n++;
         if (a_ack) begin na++; if (na == 2) a_req = 1'b0; end
         if (b_ack) begin nb++; if (nb == 2) b_req = 1'b0; end
      end
      check("tie_ack_count", 32'(na + nb), 32'd4);
      a_req = 1'b0; b_req = 1'b0;
      wait_idle();

      // Reset in the middle of a write, with an A read pending across it.
      issue(1'b1, 1'b0, 16'h0042, 8'h77);
      n = 0;
      while (sram_we_n && n < 20) begin @(negedge clk); n++; end
      check("wr_started", 32'(sram_we_n), 32'd0);
      #1 rst_n = 1'b0;
      ack_q.delete();
      done_q.delete();
      #1;
      check("abort_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
      check("abort_bus", 32'(sram_d), 32'hFF);
      check("abort_no_done", 32'({a_done, b_done}), 32'h0);
      a_rnw = 1'b1; a_addr = 16'h1234; a_req = 1'b1;
      ack_q.push_back(1'b0);
      done_q.push_back(mk(1'b0, 1'b1, 16'h1234, 8'h5A));
      repeat (3) begin
         @(negedge clk);
         check("abort_quiet", 32'({a_ack, b_ack, a_done, b_done}), 32'h0);
      end
      rst_n = 1'b1;
      wait_ack(1'b0, "post_reset");
      wait_idle();

      // Wait-state sweep: three back-to-back reads per instance.
      sw_na[0] = 0; sw_na[1] = 0;
      sw_req[0] = 1'b1; sw_req[1] = 1'b1;
      n = 0;
      while ((sw_req[0] || sw_req[1]) && n < 200) begin
         @(negedge clk); n++;
         for (int k = 0; k < 2; k++)
            if (sw_ack[k]) begin sw_na[k]++; if (sw_na[k] == 3) sw_req[k] = 1'b0; end
      end
      sw_req[0] = 1'b0; sw_req[1] = 1'b0;
      n = 0;
      while ((sw_nd[0] < 3 || sw_nd[1] < 3) && n < 60) begin @(negedge clk); n++; end
      check("sw1_done_count", 32'(sw_nd[0]), 32'd3);
      check("sw5_done_count", 32'(sw_nd[1]), 32'd3);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port arbiter and sequencer for the external 64K x 8 asynchronous SRAM (active-low ce_n/oe_n/we_n, shared bidirectional data bus).
- Sits between two internal requesters (port A: CPU side, port B: DMA/video side) and the SRAM pins.
- Arbitrates round-robin, then generates multi-cycle read and write strobe sequences with programmable wait states and bus turnaround.

Parameters:
- AW, 16, address width.
- DW, 8, data width.
- RD_WAIT, 2, cycles oe_n is held low before data is sampled (>=1).
- WR_WAIT, 2, cycles we_n is held low (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  port A request, level.
- a_rnw  in  1  port A: 1 = read, 0 = write.
- a_addr  in  AW  port A address.
- a_wdata  in  DW  port A write data.
- a_ack  out  1  port A grant pulse; request fields captured.
- a_done  out  1  port A completion pulse.
- b_req, b_rnw, b_addr, b_wdata, b_ack, b_done  same as port A, for port B.
- rdata  out  DW  read data; valid when the matching x_done is high.
- sram_addr  out  AW  SRAM address pins.
- sram_d  inout  DW  SRAM data bus.
- sram_ce_n, sram_oe_n, sram_we_n  out  1  SRAM strobes.

Behaviour:
- Reset: async on rst_n low.
  - State IDLE; ce_n/oe_n/we_n = 1; sram_d = Z; sram_addr = 0; rdata = 0.
  - a_ack, b_ack, a_done, b_done = 0; last-served pointer = B, so A wins the first tie.
  - Reset mid-access aborts immediately: strobes high and bus Z within the reset, with no done pulse.
- All outputs are registered; sram_d is driven from a registered output-enable.
- FSM states: IDLE, SETUP, RD, WR, END.
- IDLE:
  - If any req is high, select the winner: the sole requester, or on a tie the port not last served.
  - Capture addr/rnw/wdata of the winner, pulse its x_ack for 1 cycle, update last-served, go to SETUP.
  - With no req, stay in IDLE with strobes high.
- SETUP (1 cycle): sram_addr valid, ce_n = 0, oe_n = we_n = 1. For a write, sram_d is driven with wdata. Next state is RD or WR.
- RD (RD_WAIT cycles): ce_n = 0, oe_n = 0.
  - On the last RD cycle, sram_d is sampled into rdata.
  - Next state END; the winner's x_done is high during END.
- WR (WR_WAIT cycles): ce_n = 0, we_n = 0, sram_d driven. Next state END; x_done is high during END.
- END (1 cycle):
  - we_n = oe_n = 1 and ce_n = 0.
  - sram_d stays driven after a write (data hold); after a read the controller does not drive it.
  - Next state IDLE; ce_n returns to 1 and sram_d to Z in IDLE.
- Cycle counts:
  - Read occupies 1 + RD_WAIT + 1 cycles after the grant edge, plus 1 IDLE cycle.
  - Read period = RD_WAIT + 3 cycles per access; write period = WR_WAIT + 3.
- Wait counter: width ceil(log2(max(RD_WAIT, WR_WAIT)+1)); it loads on entry to RD/WR and counts down to 1.
- Handshake rules:
  - Requester holds req and its fields stable until x_ack; fields are don't-care afterwards.
  - req still high after x_ack is a new request.
  - Requests are never lost. A request arriving during a busy access waits in IDLE arbitration.
  - Back-to-back requests from both ports strictly alternate.
- Strobe invariants:
  - oe_n and we_n are never low simultaneously.
  - The controller never drives sram_d while oe_n = 0.
  - Exactly one x_done per x_ack.
- rdata holds its value until the next read sample. x_done after a write does not change rdata.

Test Plan:
- Reset then single read: a_req = 1, a_rnw = 1, a_addr = 16'h1234, SRAM model holds 8'h5A there, RD_WAIT = 2 -> a_ack 1 cycle, oe_n low exactly 2 cycles, a_done with rdata = 8'h5A on cycle 4 after the grant edge.
- Single write: b_req, b_rnw = 0, b_addr = 16'hFFFF, b_wdata = 8'hC3, WR_WAIT = 2 -> we_n low 2 cycles with sram_d = C3 through END; b_done once; readback returns C3.
- Tie arbitration: a_req and b_req held high for 4 accesses -> grant order A, B, A, B; 4 acks, 4 dones, no overlap.
- Async reset asserted mid-WR -> strobes high and sram_d Z immediately, no done; after release, a pending a_req is served normally.
- Wait-state sweep RD_WAIT = 1 and 5 with WR_WAIT = 3 -> oe_n low width equals RD_WAIT and read period equals RD_WAIT + 3. Bus-conflict checker (oe_n low while sram_d driven) never fires.
